// File: rtl/ca_pkg.sv
// ============================================================================
// Module  : ca_pkg
// Brief   : Shared sizes and reader state encoding for the Rule 110 array slice.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ca_pkg;

   localparam int CA_CELLS  = 512;
   localparam int CA_WORD_W = 32;
   localparam int CA_GEN_W  = 16;

`ifdef CA_READER_HDR_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      HDR    = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1
   } state_t;
`endif

endpackage

`default_nettype wire

// File: rtl/ca_state_reader_if.sv
// ============================================================================
// Module  : ca_state_reader_if
// Brief   : Valid/ready word stream carrying snapshot beats to a narrow consumer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface ca_state_reader_if #(
   parameter int WORD_W = ca_pkg::CA_WORD_W
);
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic [WORD_W-1:0] out_data;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );
endinterface

`default_nettype wire

// File: rtl/ca_state_reader.sv
// ============================================================================
// Module  : ca_state_reader
// Brief   : Snapshots the automaton cell vector and streams it LSB word first;
//           CA_READER_HDR_EN prepends a generation-tag header beat per frame.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ca_state_reader
   import ca_pkg::*;
#(
   parameter int CELLS  = CA_CELLS,
   parameter int WORD_W = CA_WORD_W
) (
   input  wire logic                clk,
   input  wire logic                areset_n,
   input  wire logic [CELLS-1:0]    cells,
   input  wire logic                gen_tick,
   input  wire logic                snap_req,
   output logic                     busy,
   output logic [CA_GEN_W-1:0]      gen_count,
   ca_state_reader_if.master        rd
);

   localparam int WORDS = CELLS / WORD_W;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WORDS - 1);
   localparam logic C_ONE_WORD = (WORDS == 1);

   state_t              r_state;
   logic [CELLS-1:0]    r_snap;
   logic [CA_GEN_W-1:0] r_gen;
   logic [IDX_W-1:0]    r_idx;
   logic                r_valid;
   logic                r_last;
   logic [WORD_W-1:0]   r_data;

   logic [WORD_W-1:0]   w_words [WORDS];
   logic                w_xfer;
   logic                w_capture;
   logic [IDX_W-1:0]    w_idx_nxt;

   generate
      for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
         assign w_words[gi] = r_snap[gi*WORD_W +: WORD_W];
      end
   endgenerate

   assign w_xfer    = r_valid & rd.out_ready;
   // A request coinciding with the final transfer restarts without an idle bubble.
   assign w_capture = snap_req & ((r_state == IDLE) | (w_xfer & r_last));
   assign w_idx_nxt = r_idx + 1'b1;

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         r_state <= IDLE;
         r_snap  <= '0;
         r_gen   <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= '0;
      end else begin
         if (gen_tick) begin
            r_gen <= r_gen + 1'b1;
         end

         if (w_capture) begin
            r_snap  <= cells;
            r_idx   <= '0;
            r_valid <= 1'b1;
`ifdef CA_READER_HDR_EN
            r_state <= HDR;
            r_data  <= WORD_W'(r_gen);
            r_last  <= 1'b0;
`else
            r_state <= STREAM;
            r_data  <= cells[WORD_W-1:0];
            r_last  <= C_ONE_WORD;
`endif
         end else if (w_xfer) begin
`ifdef CA_READER_HDR_EN
            if (r_state == HDR) begin
               r_state <= STREAM;
               r_data  <= w_words[0];
               r_last  <= C_ONE_WORD;
            end else
`endif
            if (r_last) begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_last  <= 1'b0;
            end else begin
               r_idx  <= w_idx_nxt;
               r_data <= w_words[w_idx_nxt];
               r_last <= (w_idx_nxt == C_LAST_IDX);
            end
         end
      end
   end

   assign busy         = (r_state != IDLE);
   assign gen_count    = r_gen;
   assign rd.out_valid = r_valid;
   assign rd.out_last  = r_last;
   assign rd.out_data  = r_data;

endmodule

`default_nettype wire
